// File: rtl/gate_model_bist.sv
// Self-test harness for one combinational (optionally pipelined) gate model.
// A Galois LFSR drives pseudo-random patterns into the model. The responses
// are folded into a MISR signature. At the end of a run the signature is
// compared with the expected value captured at start.
module gate_model_bist #(
    parameter int               IN_W      = 10,
    parameter int               OUT_W     = 10,
    parameter logic [IN_W-1:0]  LFSR_POLY = 10'h240,
    parameter logic [IN_W-1:0]  LFSR_SEED = 10'h001,
    parameter logic [OUT_W-1:0] MISR_POLY = 10'h009,
    parameter int               DUT_LAT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      num_pat,
    input  logic [OUT_W-1:0] exp_sig,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature,
    output logic [15:0]      pat_idx
);

    // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
    localparam logic [IN_W-1:0] SEED =
        (LFSR_SEED == '0) ? {{(IN_W-1){1'b0}}, 1'b1} : LFSR_SEED;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IN_W-1:0]  lfsr_q, lfsr_d;
    logic [OUT_W-1:0] sig_q, sig_d;
    logic [15:0]      patIdx_q, patIdx_d;
    logic [15:0]      numPat_q, numPat_d;
    logic [OUT_W-1:0] expSig_q, expSig_d;
    logic [1:0]       flushCnt_q, flushCnt_d;

    logic [IN_W-1:0]  lfsrNext;
    logic [OUT_W-1:0] misrNext;
    logic [15:0]      patIdxInc;
    logic             runValid;
    logic             capValid;
    logic             abortHit;

    // Galois LFSR step, MISR step and pattern counter increment.
    always_comb begin
        lfsrNext  = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_POLY) : (lfsr_q >> 1);
        misrNext  = {sig_q[OUT_W-2:0], 1'b0}
                  ^ ({OUT_W{sig_q[OUT_W-1]}} & MISR_POLY)
                  ^ dut_out;
        patIdxInc = patIdx_q + 16'd1;
        abortHit  = abort && (state_q == RUN || state_q == FLUSH);
        runValid  = (state_q == RUN) && !abort;
    end

    // The valid bit of each applied pattern is delayed to line up with the
    // model's registered response; with no latency it is used directly.
    if (DUT_LAT == 0) begin : g_noPipe
        assign capValid = runValid;
    end else begin : g_pipe
        logic [DUT_LAT-1:0] pipe_q;

        // Capture-valid shift register, flushed on abort so no stale response is compacted later.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pipe_q <= '0;
            end else if (abortHit) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= (pipe_q << 1) | DUT_LAT'(runValid);
            end
        end

        assign capValid = pipe_q[DUT_LAT-1];
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED;
            sig_q      <= '0;
            patIdx_q   <= '0;
            numPat_q   <= '0;
            expSig_q   <= '0;
            flushCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            sig_q      <= sig_d;
            patIdx_q   <= patIdx_d;
            numPat_q   <= numPat_d;
            expSig_q   <= expSig_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    // Next-state logic: launch from IDLE/DONE, count patterns in RUN, drain the pipe in FLUSH.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        sig_d      = sig_q;
        patIdx_d   = patIdx_q;
        numPat_d   = numPat_q;
        expSig_d   = expSig_q;
        flushCnt_d = flushCnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    numPat_d = num_pat;
                    expSig_d = exp_sig;
                    lfsr_d   = SEED;
                    sig_d    = '0;
                    patIdx_d = '0;
                    state_d  = (num_pat == 16'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    lfsr_d   = lfsrNext;
                    patIdx_d = patIdxInc;
                    if (patIdxInc == numPat_q) begin
                        state_d    = (DUT_LAT == 0) ? DONE : FLUSH;
                        flushCnt_d = '0;
                    end
                end
            end
            FLUSH: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (flushCnt_q == 2'(DUT_LAT - 1)) begin
                    state_d = DONE;
                end else begin
                    flushCnt_d = flushCnt_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capValid && !abortHit) begin
            sig_d = misrNext;
        end
    end

    // Outputs are decoded from state so an asynchronous reset clears them at once.
    always_comb begin
        busy      = (state_q == RUN) || (state_q == FLUSH);
        done      = (state_q == DONE);
        pass      = (state_q == DONE) && (sig_q == expSig_q);
        dut_in    = (state_q == RUN) ? lfsr_q : '0;
        signature = sig_q;
        pat_idx   = patIdx_q;
    end

endmodule

// File: tb/tb_gate_model_bist.sv
// Testbench for gate_model_bist: one instance with a combinational gate model
// and one with a two-stage registered gate model, driven with the same stimulus
// and checked against a pattern/signature model built from the LFSR/MISR rules.
module tb_gate_model_bist;

   logic        clock;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [15:0] numPatIn;
   logic [9:0]  expSigIn;
   int          mode;

   logic [9:0]  dutIn0, dutOut0, sig0;
   logic        busy0, done0, pass0;
   logic [15:0] patIdx0;

   logic [9:0]  dutIn2, dutOut2, sig2;
   logic        busy2, done2, pass2;
   logic [15:0] patIdx2;
   logic [9:0]  stage1, stage2;

   int checks;
   int failures;

   logic [9:0] pats [$];
   logic [9:0] partSig [$];

   // Gate model library: wire, constant zero, and a scrambling function.
   function automatic logic [9:0] gateFn(input int md, input logic [9:0] x);
      case (md)
         0:       return x;
         1:       return 10'd0;
         default: return {x[4:0], x[9:5]} ^ {x[8:0], 1'b0} ^ 10'h155;
      endcase
   endfunction

   function automatic logic [9:0] lfsrStep(input logic [9:0] x);
      if (x % 2 == 1) return (x / 2) ^ 10'h240;
      return x / 2;
   endfunction

   function automatic logic [9:0] misrStep(input logic [9:0] s, input logic [9:0] r);
      logic [9:0] shifted;
      shifted = 10'((s * 2) % 1024);
      if (s >= 10'd512) shifted = shifted ^ 10'h009;
      return shifted ^ r;
   endfunction

   gate_model_bist #(.DUT_LAT(0)) dut0 (
      .clk(clock), .rst_n(rst_n), .start(start), .abort(abort),
      .num_pat(numPatIn), .exp_sig(expSigIn), .dut_in(dutIn0), .dut_out(dutOut0),
      .busy(busy0), .done(done0), .pass(pass0), .signature(sig0), .pat_idx(patIdx0)
   );

   gate_model_bist #(.DUT_LAT(2)) dut2 (
      .clk(clock), .rst_n(rst_n), .start(start), .abort(abort),
      .num_pat(numPatIn), .exp_sig(expSigIn), .dut_in(dutIn2), .dut_out(dutOut2),
      .busy(busy2), .done(done2), .pass(pass2), .signature(sig2), .pat_idx(patIdx2)
   );

   assign dutOut0 = gateFn(mode, dutIn0);
   assign dutOut2 = stage2;

   // Two-stage registered version of the gate model for the latency-2 instance.
   always @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         stage1 <= 10'd0;
         stage2 <= 10'd0;
      end else begin
         stage1 <= gateFn(mode, dutIn2);
         stage2 <= stage1;
      end
   end

   // Free-running clock, period 10.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Expected pattern sequence and signature after each number of compactions.
   task automatic buildModel(input int n, input int md);
      logic [9:0] x;
      logic [9:0] s;
      pats.delete();
      partSig.delete();
      x = 10'd1;
      s = 10'd0;
      partSig.push_back(s);
      for (int k = 0; k < n; k++) begin
         pats.push_back(x);
         s = misrStep(s, gateFn(md, x));
         partSig.push_back(s);
         x = lfsrStep(x);
      end
   endtask

   task automatic checkZeros(input string tag);
      checkOutput({tag, "_busy0"}, busy0, 0);
      checkOutput({tag, "_done0"}, done0, 0);
      checkOutput({tag, "_pass0"}, pass0, 0);
      checkOutput({tag, "_sig0"}, sig0, 0);
      checkOutput({tag, "_idx0"}, patIdx0, 0);
      checkOutput({tag, "_din0"}, dutIn0, 0);
      checkOutput({tag, "_busy2"}, busy2, 0);
      checkOutput({tag, "_done2"}, done2, 0);
      checkOutput({tag, "_sig2"}, sig2, 0);
      checkOutput({tag, "_idx2"}, patIdx2, 0);
   endtask

   // Checks one instance in cycle c after the start edge of an n-pattern run.
   task automatic expectCycle(input int inst, input int c, input int n, input logic [9:0] exp);
      int         lat;
      int         k;
      string      pfx;
      logic       b, d, p;
      logic [9:0] din, s;
      logic [15:0] idx;
      lat = (inst == 0) ? 0 : 2;
      if (inst == 0) begin
         b = busy0; d = done0; p = pass0; din = dutIn0; s = sig0; idx = patIdx0;
      end else begin
         b = busy2; d = done2; p = pass2; din = dutIn2; s = sig2; idx = patIdx2;
      end
      pfx = $sformatf("lat%0d_n%0d_c%0d", lat, n, c);
      k = c - 1 - lat;
      if (k < 0) k = 0;
      if (k > n) k = n;
      checkOutput({pfx, "_sig"}, s, partSig[k]);
      if (n == 0 || c > n + lat) begin
         checkOutput({pfx, "_busy"}, b, 0);
         checkOutput({pfx, "_done"}, d, 1);
         checkOutput({pfx, "_din"}, din, 0);
         checkOutput({pfx, "_idx"}, idx, n);
         checkOutput({pfx, "_pass"}, p, (partSig[n] == exp) ? 1 : 0);
      end else if (c <= n) begin
         checkOutput({pfx, "_busy"}, b, 1);
         checkOutput({pfx, "_done"}, d, 0);
         checkOutput({pfx, "_pass"}, p, 0);
         checkOutput({pfx, "_din"}, din, pats[c-1]);
         checkOutput({pfx, "_dinNonZero"}, (din != 10'd0) ? 1 : 0, 1);
         checkOutput({pfx, "_idx"}, idx, c - 1);
      end else begin
         checkOutput({pfx, "_busy"}, b, 1);
         checkOutput({pfx, "_done"}, d, 0);
         checkOutput({pfx, "_pass"}, p, 0);
         checkOutput({pfx, "_din"}, din, 0);
         checkOutput({pfx, "_idx"}, idx, n);
      end
   endtask

   // Launches a run and checks both instances every cycle until both are done,
   // optionally poking start while busy, aborting, or resetting mid-run.
   task automatic applyStimulus(input int n, input logic [9:0] exp, input int md,
                                input bit pokeStart, input int abortAt, input int resetAt);
      int total;
      int k;
      buildModel(n, md);
      @(negedge clock);
      mode     = md;
      numPatIn = 16'(n);
      expSigIn = exp;
      start    = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      total = (n == 0) ? 2 : n + 3;
      for (int c = 1; c <= total; c++) begin
         @(negedge clock);
         start = 1'b0;
         expectCycle(0, c, n, exp);
         expectCycle(1, c, n, exp);
         if (pokeStart && c == 2 && n >= 4) begin
            start    = 1'b1;
            numPatIn = 16'($urandom_range(1, 5));
            expSigIn = 10'($urandom);
         end
         if (abortAt != 0 && c == abortAt + 1) begin
            abort = 1'b1;
            @(posedge clock);
            #1 abort = 1'b0;
            @(negedge clock);
            checkOutput("abort_busy0", busy0, 0);
            checkOutput("abort_done0", done0, 0);
            checkOutput("abort_din0", dutIn0, 0);
            checkOutput("abort_idx0", patIdx0, abortAt);
            checkOutput("abort_sig0", sig0, partSig[c-1]);
            checkOutput("abort_busy2", busy2, 0);
            checkOutput("abort_done2", done2, 0);
            checkOutput("abort_idx2", patIdx2, abortAt);
            k = (c - 3 < 0) ? 0 : c - 3;
            checkOutput("abort_sig2", sig2, partSig[k]);
            return;
         end
         if (resetAt != 0 && c == resetAt + 1) begin
            checkOutput("preReset_idx0", patIdx0, resetAt);
            #2 rst_n = 1'b0;
            #1 checkZeros("midReset");
            @(negedge clock);
            rst_n = 1'b1;
            return;
         end
      end
   endtask

   // Bounds the whole run in case the design never settles.
   initial begin
      #600000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios followed by randomized runs.
   initial begin
      int         n;
      int         md;
      logic [9:0] exp;
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      numPatIn = 16'd0;
      expSigIn = 10'd0;
      mode     = 0;
      #3 checkZeros("reset");
      #20;
      @(negedge clock);
      rst_n = 1'b1;

      applyStimulus(2, 10'h242, 0, 1'b0, 0, 0);
      checkOutput("wire2_sig", sig0, 10'h242);
      checkOutput("wire2_pass", pass0, 1);
      checkOutput("wire2_sigLat2", sig2, 10'h242);

      applyStimulus(1000, 10'h000, 1, 1'b0, 0, 0);
      checkOutput("const1000_idx", patIdx0, 1000);

      applyStimulus(0, 10'h3FF, 0, 1'b0, 0, 0);

      buildModel(1023, 0);
      checkOutput("period_wrap", lfsrStep(pats[1022]), 10'h001);
      applyStimulus(1023, partSig[1023], 0, 1'b0, 0, 0);
      applyStimulus(1023, 10'h000, 0, 1'b0, 500, 0);

      applyStimulus(100, 10'h000, 2, 1'b0, 0, 37);
      applyStimulus(2, 10'h242, 0, 1'b0, 0, 0);
      checkOutput("afterReset_sig", sig0, 10'h242);

      for (int r = 0; r < 10; r++) begin
         n  = $urandom_range(0, 60);
         md = $urandom_range(0, 2);
         buildModel(n, md);
         exp = ($urandom_range(0, 1) == 1) ? partSig[n] : 10'($urandom);
         applyStimulus(n, exp, md, 1'b1, 0, 0);
      end

      n  = $urandom_range(10, 50);
      md = $urandom_range(0, 2);
      applyStimulus(n, 10'h000, md, 1'b0, $urandom_range(1, n - 1), 0);
      applyStimulus(5, 10'h000, 2, 1'b0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
